wb_scrubber: RTL
================

WB_SCRUBBER -- requirements
Module: wb_scrubber

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data width of each scrubbed word.
REQ-002 SHALL have parameter REGISTERS, default 32, number of words per scrub pass.
REQ-003 SHALL have parameter REGDIRSIZE, default 5, width of the word index (log2 REGISTERS).
REQ-004 SHALL have parameter WHISBONE_ADR, default 32, Wishbone address width.
REQ-005 SHALL have parameter BASE_ADR, default 32'h3000_0000, byte address of word 0.
REQ-006 SHALL have parameter COUNTERSIZE, default 32, width of the interval and pass counters.
REQ-007 SHALL have parameter TIMEOUT, default 16, ack-wait cycles before abort (only used with SCRUB_TIMEOUT_EN).
REQ-008 SHALL have ports, one per line:
 clk_i  in  1  single clock; all state changes on its rising edge.
 rst_i  in  1  asynchronous, active-high reset.
 enable_i  in  1  level; 1 = run scrub passes, 0 = stop after the current bus cycle.
 interval_i  in  COUNTERSIZE  idle cycles between passes, sampled at pass start.
 wbm_cyc_o  out  1  Wishbone cycle.
 wbm_stb_o  out  1  Wishbone strobe.
 wbm_we_o  out  1  Wishbone write enable.
 wbm_sel_o  out  4  byte selects.
 wbm_adr_o  out  WHISBONE_ADR  byte address.
 wbm_dat_o  out  WORD_SIZE  write data.
 wbm_dat_i  in  WORD_SIZE  read data.
 wbm_ack_i  in  1  responder acknowledge.
 busy_o  out  1  high in any state other than IDLE.
 pass_done_o  out  1  one-cycle pulse when the last word of a pass is written back.
 pass_count_o  out  COUNTERSIZE  completed passes, wraps to 0.
 timeout_o  out  1  sticky ack-timeout flag (constant 0 without SCRUB_TIMEOUT_EN).

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, READ, GAP, WRITE.
REQ-010 SHALL, in IDLE with enable_i=1, load the interval counter from interval_i, clear the index, and enter WAIT.
REQ-011 SHALL, in WAIT, decrement the counter each cycle and enter READ the cycle it equals 0; interval_i=0 gives WAIT for exactly one cycle.
REQ-012 SHALL, in READ, drive cyc=stb=1, we=0, sel=4'hF, adr=BASE_ADR+(index<<2), holding all of them stable until the ack cycle.
REQ-013 SHALL, on the READ ack cycle, capture wbm_dat_i into the writeback register and enter GAP.
REQ-014 SHALL, in GAP, drive cyc=stb=0 for exactly one cycle, then enter WRITE.
REQ-015 SHALL, in WRITE, drive cyc=stb=we=1, sel=4'hF, the same adr, and dat_o=captured word until ack.
REQ-016 SHALL, on the WRITE ack cycle, drop cyc/stb the next cycle, and then:
 - index<REGISTERS-1: increment the index and go to GAP, then READ.
 - index=REGISTERS-1: pulse pass_done_o, increment pass_count_o, clear the index, and go to WAIT (enable_i=1) or IDLE (enable_i=0).
REQ-017 SHALL ignore wbm_ack_i whenever stb is low.
REQ-018 SHALL never abort a started bus cycle on enable_i=0; it SHALL complete the current READ, GAP and WRITE for that word, then go to IDLE without pulsing pass_done_o.
REQ-019 SHALL, when enable_i is deasserted in WAIT, go to IDLE the next cycle.
REQ-020 SHALL wrap pass_count_o from all-ones to 0.
REQ-021 SHALL keep wbm_dat_o at 0 outside WRITE.

Reset
REQ-022 SHALL, while rst_i=1, force state IDLE; all bus outputs, busy_o, pass_done_o, pass_count_o, timeout_o, the index and the counters to 0.
REQ-023 SHALL apply reset asynchronously, including mid-transaction, with outputs at 0 immediately.
REQ-024 SHALL leave IDLE no earlier than the first rising edge after rst_i falls.

Configuration
REQ-025 SHALL use the macro SCRUB_TIMEOUT_EN to compile the ack watchdog in or out:
 - Defined: count cycles with stb=1 and no ack. When the count reaches TIMEOUT, drop cyc/stb, set timeout_o (sticky until reset), skip the word without writeback, and continue as on a WRITE ack.
 - Undefined: no watchdog logic; the block waits for ack indefinitely; timeout_o is tied to 0.

Verification
REQ-026 SHALL pass these directed scenarios:
 - REGISTERS=4, interval_i=3, ack one cycle after stb, responder data 32'hA5A5_0000+index -> reads then writes to 3000_0000, _0004, _0008, _000C with matching data; pass_done_o pulses once; pass_count_o=1.
 - interval_i=0, enable_i held 1 -> back-to-back passes, each separated by one WAIT cycle; pass_count_o increments per pass.
 - enable_i dropped during READ of index 2 -> index 2 write completes, then IDLE; pass_done_o stays 0; busy_o goes 0.
 - rst_i asserted during WRITE -> cyc/stb/we go 0 with no clock edge; pass_count_o=0.
 - SCRUB_TIMEOUT_EN, TIMEOUT=16, ack withheld on index 1 -> stb drops after 16 cycles; timeout_o=1; index 1 gets no write; index 2 is read next.
 - pass_count_o preloaded to all-ones (COUNTERSIZE=4) -> wraps to 0 after the next pass.

Source files
------------

// File: rtl/wb_scrubber.sv
// Wishbone memory scrubber: reads each word of a window and writes it straight back, pass after pass.
// Define SCRUB_TIMEOUT_EN to compile in the ack watchdog (sticky timeout_o, word skipped on expiry).
module wb_scrubber #(
    parameter int                      WORD_SIZE    = 32,
    parameter int                      REGISTERS    = 32,
    parameter int                      REGDIRSIZE   = 5,
    parameter int                      WHISBONE_ADR = 32,
    parameter logic [WHISBONE_ADR-1:0] BASE_ADR     = 32'h3000_0000,
    parameter int                      COUNTERSIZE  = 32,
    parameter int                      TIMEOUT      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [COUNTERSIZE-1:0]  interval_i,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [3:0]              wbm_sel_o,
    output logic [WHISBONE_ADR-1:0] wbm_adr_o,
    output logic [WORD_SIZE-1:0]    wbm_dat_o,
    input  logic [WORD_SIZE-1:0]    wbm_dat_i,
    input  logic                    wbm_ack_i,
    output logic                    busy_o,
    output logic                    pass_done_o,
    output logic [COUNTERSIZE-1:0]  pass_count_o,
    output logic                    timeout_o
);

    typedef enum logic [2:0] {IDLE, WAIT, READ, GAP, WRITE} state_t;

    state_t                 state, next_state;
    logic [REGDIRSIZE-1:0]  idx;
    logic [COUNTERSIZE-1:0] cnt;
    logic [WORD_SIZE-1:0]   wb_data;
    logic                   gap_to_write;
    logic                   pass_done;
    logic [COUNTERSIZE-1:0] pass_count;
    logic                   stb, ack, wd_hit, word_done, last;

    assign stb       = (state == READ) || (state == WRITE);
    assign ack       = stb && wbm_ack_i;
    assign last      = (idx == REGDIRSIZE'(REGISTERS - 1));
    // A watchdog expiry in either phase retires the word exactly like a write ack.
    assign word_done = ((state == WRITE) && ack) || wd_hit;

`ifdef SCRUB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           timeout;

    assign wd_hit = stb && !wbm_ack_i && (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (stb && !wbm_ack_i && !wd_hit) wd_cnt <= wd_cnt + WDW'(1);
            else                              wd_cnt <= '0;
            if (wd_hit) timeout <= 1'b1;
        end
    end

    assign timeout_o = timeout;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign wd_hit         = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable_i) next_state = WAIT;
            WAIT: begin
                if (!enable_i)       next_state = IDLE;
                else if (cnt == '0)  next_state = READ;
            end
            READ:  if (ack) next_state = GAP;
            // The gap before a read is where a dropped enable_i takes effect mid-pass.
            GAP: begin
                if (gap_to_write)    next_state = WRITE;
                else if (enable_i)   next_state = READ;
                else                 next_state = IDLE;
            end
            WRITE: next_state = WRITE;
            default: next_state = IDLE;
        endcase
        if (word_done) begin
            if (last) next_state = enable_i ? WAIT : IDLE;
            else      next_state = GAP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx          <= '0;
            cnt          <= '0;
            wb_data      <= '0;
            gap_to_write <= 1'b0;
            pass_done    <= 1'b0;
            pass_count   <= '0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                IDLE: if (enable_i) begin
                    cnt <= interval_i;
                    idx <= '0;
                end
                WAIT: if (cnt != '0) cnt <= cnt - COUNTERSIZE'(1);
                READ: if (ack) begin
                    wb_data      <= wbm_dat_i;
                    gap_to_write <= 1'b1;
                end
                default: ;
            endcase
            if (word_done) begin
                gap_to_write <= 1'b0;
                if (last) begin
                    idx        <= '0;
                    cnt        <= interval_i;
                    pass_done  <= 1'b1;
                    pass_count <= pass_count + COUNTERSIZE'(1);
                end else begin
                    idx <= idx + REGDIRSIZE'(1);
                end
            end
        end
    end

    // Bus outputs decode straight from state so an async reset clears them with no edge.
    assign wbm_cyc_o    = stb;
    assign wbm_stb_o    = stb;
    assign wbm_we_o     = (state == WRITE);
    assign wbm_sel_o    = stb ? 4'hF : 4'h0;
    assign wbm_adr_o    = stb ? BASE_ADR + (WHISBONE_ADR'(idx) << 2) : '0;
    assign wbm_dat_o    = (state == WRITE) ? wb_data : '0;
    assign busy_o       = (state != IDLE);
    assign pass_done_o  = pass_done;
    assign pass_count_o = pass_count;

endmodule
